// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: decoded ops, FSM states,
// accumulate modes and the operand/control bundle latched at issue.
package muldiv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [4:0] {
    OP_NOP, OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_MFHI, OP_MFLO,
    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
    OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  } op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  typedef enum logic [1:0] {SET, ADD, SUB} acc_mode_t;

  typedef struct packed {
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    acc_mode_t       mode;
    logic            sgn;
    logic            q_neg;
    logic            r_neg;
    logic            div0;
  } issue_t;

  function automatic logic is_mul_op(op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_muldiv_op(op_t op);
    return is_mul_op(op) || is_div_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_signed_op(op_t op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB, OP_DIV};
  endfunction

  function automatic acc_mode_t acc_mode_of(op_t op);
    case (op)
      OP_MADD, OP_MADDU: return ADD;
      OP_MSUB, OP_MSUBU: return SUB;
      default:           return SET;
    endcase
  endfunction

endpackage

// File: rtl/div_iter_u32.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// done is high while the final iteration is being performed.
module div_iter_u32
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [2*XLEN-1:0] rq_q;
  logic [2*XLEN-1:0] rq_nxt;
  logic [XLEN-1:0]   dvsr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN:0]     window_c;
  logic [XLEN:0]     trial_c;

  // 33-bit window so divisors above 2^31 compare correctly
  assign window_c = rq_q[2*XLEN-1:XLEN-1];
  assign trial_c  = window_c - {1'b0, dvsr_q};

  always_comb begin
    rq_nxt = {rq_q[2*XLEN-2:0], 1'b0};
    if (window_c >= {1'b0, dvsr_q}) begin
      rq_nxt = {trial_c[XLEN-1:0], rq_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rq_q   <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else if (start) begin
      rq_q   <= {{XLEN{1'b0}}, dividend};
      dvsr_q <= divisor;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else if (step) begin
      rq_q   <= rq_nxt;
      cnt_q  <= cnt_q + CNT_W'(1);
      done   <= (cnt_q == CNT_W'(DIV_ITERS - 2));
    end
  end

  assign quot = rq_q[XLEN-1:0];
  assign rem  = rq_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit owning the HI/LO registers; busy stays
// high while an operation is in flight so MFHI/MFLO consumers can stall.
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  op_t             op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            busy,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  state_t            state_q, state_nxt;
  issue_t            lat_q, lat_nxt;
  logic [XLEN-1:0]   hi_q, lo_q, hi_nxt, lo_nxt;
  logic              accept;
  logic              div_start, div_step, div_done;
  logic [XLEN-1:0]   dvd_c, dvs_c, div_quot, div_rem;
  logic [2*XLEN-1:0] mul_a_c, mul_b_c, prod_c, hilo_c;

  assign in_ready = (state_q == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  // Signed divides run on magnitudes; signs are restored in FIX
  assign dvd_c     = (is_signed_op(op) && rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign dvs_c     = (is_signed_op(op) && rt_val[XLEN-1]) ? -rt_val : rt_val;
  assign div_start = accept && is_div_op(op);
  assign div_step  = (state_q == DIV) && !flush;

  div_iter_u32 u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .step     (div_step),
    .dividend (dvd_c),
    .divisor  (dvs_c),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Sign-extending to 64 bits makes the truncated product correct for both kinds
  assign mul_a_c = {{XLEN{lat_q.sgn & lat_q.op_a[XLEN-1]}}, lat_q.op_a};
  assign mul_b_c = {{XLEN{lat_q.sgn & lat_q.op_b[XLEN-1]}}, lat_q.op_b};
  assign prod_c  = mul_a_c * mul_b_c;
  assign hilo_c  = {hi_q, lo_q};

  always_comb begin
    state_nxt = state_q;
    lat_nxt   = lat_q;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept && is_muldiv_op(op)) begin
          if (op == OP_MTHI) begin
            hi_nxt = rs_val;
          end else if (op == OP_MTLO) begin
            lo_nxt = rs_val;
          end else begin
            lat_nxt.op_a  = rs_val;
            lat_nxt.op_b  = rt_val;
            lat_nxt.mode  = acc_mode_of(op);
            lat_nxt.sgn   = is_signed_op(op);
            lat_nxt.q_neg = is_signed_op(op) && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            lat_nxt.r_neg = is_signed_op(op) && rs_val[XLEN-1];
            lat_nxt.div0  = (rt_val == '0);
            state_nxt     = is_div_op(op) ? DIV : MUL;
          end
        end
      end
      MUL: begin
        state_nxt = IDLE;
        if (!flush) begin
          case (lat_q.mode)
            ADD:     {hi_nxt, lo_nxt} = hilo_c + prod_c;
            SUB:     {hi_nxt, lo_nxt} = hilo_c - prod_c;
            default: {hi_nxt, lo_nxt} = prod_c;
          endcase
        end
      end
      DIV: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (div_done) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        if (!flush) begin
          if (lat_q.div0) begin
            lo_nxt = '1;
            hi_nxt = lat_q.op_a;
          end else begin
            lo_nxt = lat_q.q_neg ? -div_quot : div_quot;
            hi_nxt = lat_q.r_neg ? -div_rem : div_rem;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      lat_q   <= lat_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
